bcd_convert_arbiter: RTL and testbench

Round-robin scheduler that shares one SumOfNumbers2_10 binary-to-BCD converter between `numRequesters` clients. It accepts one request at a time and drives the converter's `binaryNumber`/`load` inputs. It waits for `to2_10Sum`, then returns the captured `BinaryDecimal` to the granted client tagged with its ID. A timeout guards against a converter that never reports completion.

---
 rtl/bcd_convert_arbiter_if.sv | 33 +++
 rtl/bcd_convert_arbiter.sv | 106 ++++++++++
 tb/tb_bcd_convert_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_convert_arbiter_if.sv
// bcd_convert_arbiter_if: client request/response and converter signal bundle
//   slave  : arbiter side (drives ack, conv_binaryNumber/conv_load, rsp_*, busy)
//   master : clients + converter side (drives req/reqNumber, conv_BinaryDecimal/conv_to2_10Sum)
interface bcd_convert_arbiter_if #(
    parameter int numRequesters     = 4,
    parameter int binaryNumberWidth = 32,
    parameter int busWidth          = 4,
    parameter int numberOfDigits    = 3
);
    localparam int id_w = $clog2(numRequesters);
    logic [numRequesters-1:0]                         req;
    logic [numRequesters-1:0][binaryNumberWidth-1:0]  reqNumber;
    logic [numRequesters-1:0]                         ack;
    logic [binaryNumberWidth-1:0]                     conv_binaryNumber;
    logic                                             conv_load;
    logic [numberOfDigits-1:0][busWidth-1:0]          conv_BinaryDecimal;
    logic                                             conv_to2_10Sum;
    logic                                             rsp_valid;
    logic [id_w-1:0]                                  rsp_id;
    logic [numberOfDigits-1:0][busWidth-1:0]          rsp_BinaryDecimal;
    logic                                             rsp_timeout;
    logic                                             busy;
    modport slave (
        input  req, reqNumber, conv_BinaryDecimal, conv_to2_10Sum,
        output ack, conv_binaryNumber, conv_load, rsp_valid, rsp_id,
               rsp_BinaryDecimal, rsp_timeout, busy
    );
    modport master (
        output req, reqNumber, conv_BinaryDecimal, conv_to2_10Sum,
        input  ack, conv_binaryNumber, conv_load, rsp_valid, rsp_id,
               rsp_BinaryDecimal, rsp_timeout, busy
    );
endinterface

// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: round-robin sharing of one binary-to-BCD converter among clients
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : slave side of bcd_convert_arbiter_if (requests, converter drive, responses, busy)
module bcd_convert_arbiter #(
    parameter int numRequesters     = 4,
    parameter int binaryNumberWidth = 32,
    parameter int busWidth          = 4,
    parameter int numberOfDigits    = 3,
    parameter int timeoutCycles     = 255
) (
    input logic                  clk,
    input logic                  rst,
    bcd_convert_arbiter_if.slave bus
);
    localparam int id_w  = $clog2(numRequesters);
    localparam int tmr_w = $clog2(timeoutCycles + 1);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP} state_t;
    state_t                                  state, state_nx;
    logic [id_w-1:0]                         rr_ptr, rr_nx, gnt, k, id_nx;
    logic [tmr_w-1:0]                        timer, timer_nx;
    logic [numRequesters-1:0]                ack_nx;
    logic [binaryNumberWidth-1:0]            num_nx;
    logic [numberOfDigits-1:0][busWidth-1:0] bcd_nx;
    logic                                    load_nx, valid_nx, tout_nx, done;
    // Scan downward so the lowest offset from rr_ptr is the one left standing.
    always_comb begin
        gnt = '0;
        k   = '0;
        for (int i = numRequesters - 1; i >= 0; i--) begin
            k = id_w'((int'(rr_ptr) + i) % numRequesters);
            if (bus.req[k]) gnt = k;
        end
    end
    // A done level in the first WAIT cycle (timer still 0) may be left over from the last conversion.
    assign done = bus.conv_to2_10Sum && (timer != '0);
    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        timer_nx = timer;
        ack_nx   = '0;
        load_nx  = 1'b0;
        valid_nx = 1'b0;
        tout_nx  = 1'b0;
        num_nx   = bus.conv_binaryNumber;
        id_nx    = bus.rsp_id;
        bcd_nx   = bus.rsp_BinaryDecimal;
        case (state)
            S_IDLE: if (|bus.req) begin
                state_nx    = S_LOAD;
                num_nx      = bus.reqNumber[gnt];
                id_nx       = gnt;
                ack_nx[gnt] = 1'b1;
                load_nx     = 1'b1;
            end
            S_LOAD: begin
                state_nx = S_WAIT;
                timer_nx = '0;
            end
            S_WAIT: begin
                timer_nx = timer + 1'b1;
                if (done) begin
                    state_nx = S_RESP;
                    bcd_nx   = bus.conv_BinaryDecimal;
                    valid_nx = 1'b1;
                end else if (timer == tmr_w'(timeoutCycles - 1)) begin
                    state_nx = S_RESP;
                    bcd_nx   = '0;
                    valid_nx = 1'b1;
                    tout_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                rr_nx    = (bus.rsp_id == id_w'(numRequesters - 1)) ? '0 : bus.rsp_id + 1'b1;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= S_IDLE;
            rr_ptr                <= '0;
            timer                 <= '0;
            bus.ack               <= '0;
            bus.conv_load         <= 1'b0;
            bus.conv_binaryNumber <= '0;
            bus.rsp_valid         <= 1'b0;
            bus.rsp_id            <= '0;
            bus.rsp_BinaryDecimal <= '0;
            bus.rsp_timeout       <= 1'b0;
            bus.busy              <= 1'b0;
        end else begin
            state                 <= state_nx;
            rr_ptr                <= rr_nx;
            timer                 <= timer_nx;
            bus.ack               <= ack_nx;
            bus.conv_load         <= load_nx;
            bus.conv_binaryNumber <= num_nx;
            bus.rsp_valid         <= valid_nx;
            bus.rsp_id            <= id_nx;
            bus.rsp_BinaryDecimal <= bcd_nx;
            bus.rsp_timeout       <= tout_nx;
            bus.busy              <= (state_nx != S_IDLE);
        end
    end
endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// tb_bcd_convert_arbiter: directed bench for bcd_convert_arbiter with a behavioural converter
module tb_bcd_convert_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   since = 0;
    int   dly = 6;
    bit   never = 1'b0;
    bit   stale1 = 1'b0;
    bit   hold = 1'b0;
    int   ack_cnt [4];
    int   rsp_cnt = 0;
    int   overlap = 0;
    bcd_convert_arbiter_if #(.numRequesters(4), .binaryNumberWidth(32), .busWidth(4), .numberOfDigits(3)) bus ();
    bcd_convert_arbiter #(.numRequesters(4), .binaryNumberWidth(32), .busWidth(4), .numberOfDigits(3),
                          .timeoutCycles(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [11:0] to_bcd(input logic [31:0] n);
        return {4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction
    // Converter: done and result appear dly cycles after load and stay up until the next load.
    always @(posedge clk) begin
        if (bus.conv_load) since <= 1;
        else if (since > 0) since <= since + 1;
    end
    assign bus.conv_to2_10Sum     = !never && (since >= dly || (stale1 && since == 1));
    assign bus.conv_BinaryDecimal = (since >= dly) ? to_bcd(bus.conv_binaryNumber) : 12'hEEE;
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (bus.ack[i]) ack_cnt[i] <= ack_cnt[i] + 1;
        if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (bus.rsp_valid && bus.ack != '0) overlap <= overlap + 1;
    end
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic wait_ack(output logic [3:0] a, output int c);
        a = '0;
        c = -1000;
        for (int i = 0; i < 40 && c < 0; i++) begin
            @(negedge clk);
            if (bus.ack != '0) begin
                a = bus.ack;
                c = cyc;
            end
        end
        if (!hold) bus.req = bus.req & ~a;
    endtask
    task automatic wait_rsp(output logic [1:0] id, output logic [11:0] bcd, output logic to, output int c);
        id  = '0;
        bcd = '0;
        to  = 1'b0;
        c   = -1000;
        for (int i = 0; i < 40 && c < 0; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                id  = bus.rsp_id;
                bcd = bus.rsp_BinaryDecimal;
                to  = bus.rsp_timeout;
                c   = cyc;
            end
        end
    endtask
    initial begin
        logic [3:0]  a;
        logic [1:0]  id;
        logic [11:0] bcd;
        logic        to;
        int          ca, cr, rc, a0, r0, prev;
        logic [11:0] exp_bcd [5];
        exp_bcd = '{12'h005, 12'h017, 12'h099, 12'h250, 12'h005};
        bus.req = '0;
        bus.reqNumber = '0;
        repeat (2) @(negedge clk);
        check("rst_ack", bus.ack, 0);
        check("rst_outs", {bus.conv_load, bus.rsp_valid, bus.rsp_id, bus.rsp_timeout, bus.busy}, 0);
        check("rst_data", {bus.conv_binaryNumber, bus.rsp_BinaryDecimal}, 0);
        rst = 1'b1;
        // single request from client 2
        @(negedge clk);
        a0 = ack_cnt[2];
        r0 = rsp_cnt;
        bus.reqNumber[2] = 32'h0B;
        bus.req = 4'b0100;
        rc = cyc;
        wait_ack(a, ca);
        check("t1_ack", a, 4'b0100);
        check("t1_ack_lat", ca - rc, 1);
        check("t1_load", {bus.conv_load, bus.busy}, 2'b11);
        check("t1_num", bus.conv_binaryNumber, 32'h0B);
        wait_rsp(id, bcd, to, cr);
        check("t1_id", id, 2);
        check("t1_bcd", bcd, 12'h011);
        check("t1_tout", to, 0);
        check("t1_lat", cr - ca, 7);
        @(negedge clk);
        check("t1_idle", {bus.busy, bus.rsp_valid}, 0);
        @(negedge clk);
        check("t1_ack_cnt", ack_cnt[2] - a0, 1);
        check("t1_rsp_cnt", rsp_cnt - r0, 1);
        // pointer at 3: client 0 wins by wrap, then client 2
        bus.reqNumber[0] = 32'd42;
        bus.reqNumber[2] = 32'd7;
        bus.req = 4'b0101;
        wait_ack(a, ca);
        check("wrap_ack0", a, 4'b0001);
        wait_rsp(id, bcd, to, cr);
        check("wrap_rsp0", {id, bcd}, {2'd0, 12'h042});
        wait_ack(a, ca);
        check("wrap_ack2", a, 4'b0100);
        wait_rsp(id, bcd, to, cr);
        check("wrap_rsp2", {id, bcd}, {2'd2, 12'h007});
        // done still high from the previous conversion when load goes out
        dly = 5;
        bus.reqNumber[0] = 32'd123;
        bus.req = 4'b0001;
        wait_ack(a, ca);
        check("stale_ack", a, 4'b0001);
        wait_rsp(id, bcd, to, cr);
        check("stale_bcd", bcd, 12'h123);
        check("stale_lat", cr - ca, 6);
        // done also high in the first WAIT cycle, with a bogus result
        stale1 = 1'b1;
        bus.reqNumber[1] = 32'd456;
        bus.req = 4'b0010;
        wait_ack(a, ca);
        wait_rsp(id, bcd, to, cr);
        check("stale1_bcd", bcd, 12'h456);
        check("stale1_lat", cr - ca, 6);
        check("stale1_tout", to, 0);
        stale1 = 1'b0;
        // converter never finishes
        never = 1'b1;
        bus.reqNumber[2] = 32'd77;
        bus.req = 4'b0100;
        wait_ack(a, ca);
        wait_rsp(id, bcd, to, cr);
        check("to_flag", to, 1);
        check("to_bcd", bcd, 0);
        check("to_id", id, 2);
        check("to_lat", cr - ca, 9);
        never = 1'b0;
        // done arrives exactly at the limit cycle: done wins
        dly = 8;
        bus.reqNumber[3] = 32'd250;
        bus.req = 4'b1000;
        wait_ack(a, ca);
        check("edge_ack", a, 4'b1000);
        wait_rsp(id, bcd, to, cr);
        check("edge_rsp", {to, bcd}, {1'b0, 12'h250});
        check("edge_lat", cr - ca, 9);
        dly = 3;
        bus.reqNumber[0] = 32'd31;
        bus.req = 4'b0001;
        wait_ack(a, ca);
        wait_rsp(id, bcd, to, cr);
        check("after_to", {to, id, bcd}, {1'b0, 2'd0, 12'h031});
        check("after_to_lat", cr - ca, 4);
        // asynchronous reset in the middle of WAIT
        dly = 6;
        bus.reqNumber[3] = 32'd9;
        bus.req = 4'b1000;
        wait_ack(a, ca);
        check("rw_ack", a, 4'b1000);
        repeat (2) @(negedge clk);
        bus.reqNumber[1] = 32'd64;
        bus.req[1] = 1'b1;
        r0 = rsp_cnt;
        #2 rst = 1'b0;
        #1;
        check("rw_outs", {bus.ack, bus.conv_load, bus.rsp_valid, bus.rsp_id, bus.rsp_timeout, bus.busy}, 0);
        check("rw_data", {bus.conv_binaryNumber, bus.rsp_BinaryDecimal}, 0);
        repeat (2) @(negedge clk);
        check("rw_hold", {bus.ack, bus.busy}, 0);
        rst = 1'b1;
        rc = cyc;
        wait_ack(a, ca);
        check("rw_ack1", a, 4'b0010);
        check("rw_ack1_lat", ca - rc, 1);
        wait_rsp(id, bcd, to, cr);
        check("rw_rsp1", {id, bcd}, {2'd1, 12'h064});
        check("rw_lat", cr - ca, 7);
        check("rw_dropped", rsp_cnt - r0, 0);
        // all four requesting from reset, fastest converter
        @(negedge clk);
        rst = 1'b0;
        dly = 2;
        hold = 1'b1;
        bus.reqNumber = {32'd250, 32'd99, 32'd17, 32'd5};
        bus.req = 4'b1111;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            wait_ack(a, ca);
            check("rr_ack", a, 4'b0001 << (n % 4));
            if (n > 0) check("rr_spacing", ca - prev, 5);
            prev = ca;
            wait_rsp(id, bcd, to, cr);
            check("rr_rsp", {id, bcd}, {2'(n % 4), exp_bcd[n]});
            check("rr_lat", cr - ca, 3);
        end
        bus.req = '0;
        hold = 1'b0;
        repeat (8) @(negedge clk);
        check("ack_rsp_overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
